// File: rtl/csla_pkg.sv
// Shared types and constants for the carry-select adder and the arbiter that
// time-shares it between several requesters.
package csla_pkg;

    localparam int CSLA_W   = 32;
    // Carry-select block width; CSLA_W must be a multiple of it.
    localparam int CSLA_BLK = 4;

    typedef logic [CSLA_W-1:0] csla_word_t;

    typedef struct packed {
        logic       cout;
        csla_word_t sum;
    } csla_result_t;

endpackage

// File: rtl/csla.sv
// 32-bit carry-select adder: each 4-bit block precomputes sums for both
// possible carry-ins and the ripple of block carries picks one.
module csla
    import csla_pkg::*;
(
    input  logic [CSLA_W-1:0] x,
    input  logic [CSLA_W-1:0] y,
    output logic [CSLA_W-1:0] s,
    output logic              cout
);

    localparam int NBLK = CSLA_W / CSLA_BLK;

    logic [NBLK:0] c;

    assign c[0] = 1'b0;

    for (genvar b = 0; b < NBLK; b++) begin : g_blk
        logic [CSLA_BLK:0] s0;
        logic [CSLA_BLK:0] s1;

        assign s0 = {1'b0, x[b*CSLA_BLK +: CSLA_BLK]} + {1'b0, y[b*CSLA_BLK +: CSLA_BLK]};
        assign s1 = {1'b0, x[b*CSLA_BLK +: CSLA_BLK]} + {1'b0, y[b*CSLA_BLK +: CSLA_BLK]}
                    + (CSLA_BLK+1)'(1);

        assign s[b*CSLA_BLK +: CSLA_BLK] = c[b] ? s1[CSLA_BLK-1:0] : s0[CSLA_BLK-1:0];
        assign c[b+1]                    = c[b] ? s1[CSLA_BLK]     : s0[CSLA_BLK];
    end

    assign cout = c[NBLK];

endmodule

// File: rtl/csla_arbiter_rr_arb.sv
// Round-robin winner search: the first valid requester at or after ptr wins,
// and ptr_next points just past the winner.
module csla_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_vld,
    output logic [ID_W-1:0]    ptr_next
);

    int             idx;
    logic [ID_W-1:0] sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        ptr_next  = ptr;
        idx       = 0;
        sel       = '0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                // Rotate the search start without a modulo operator.
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                sel = ID_W'(idx);
                if (!grant_vld && req_valid[sel]) begin
                    grant[sel] = 1'b1;
                    grant_idx  = sel;
                    grant_vld  = 1'b1;
                    ptr_next   = (sel == ID_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/csla_arbiter.sv
// Shares one carry-select adder among NUM_REQ requesters: round-robin grant
// into an operand register, adder, then a result register on a response port.
module csla_arbiter
    import csla_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*CSLA_W-1:0] req_x,
    input  logic [NUM_REQ*CSLA_W-1:0] req_y,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [CSLA_W-1:0]         rsp_sum,
    output logic                      rsp_cout
);

    // Handshakes: a beat moves when valid && ready on the same rising edge.
    // Producers hold valid and payload stable until accepted; req_ready is
    // a function of arbitration state and req_valid only, never of payload.

    logic         op_vld_q, op_vld_d;
    logic [ID_W-1:0] op_id_q, op_id_d;
    csla_word_t   op_x_q, op_x_d;
    csla_word_t   op_y_q, op_y_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    csla_result_t rsp_res_q, rsp_res_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic               adv_a;
    logic               adv_b;
    logic               arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;
    logic [ID_W-1:0]    ptr_next;
    csla_word_t         sel_x;
    csla_word_t         sel_y;
    csla_word_t         csla_sum;
    logic               csla_cout;

    assign adv_b  = op_vld_q && (!rsp_valid_q || rsp_ready);
    assign adv_a  = !op_vld_q || adv_b;
    // Gating with rst_n keeps req_ready low for the whole reset window.
    assign arb_en = adv_a && rst_n;

    csla_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .ptr_next  (ptr_next)
    );

    assign req_ready = grant;

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_x = req_x[i*CSLA_W +: CSLA_W];
                sel_y = req_y[i*CSLA_W +: CSLA_W];
            end
        end
    end

    csla u_csla (
        .x    (op_x_q),
        .y    (op_y_q),
        .s    (csla_sum),
        .cout (csla_cout)
    );

    always_comb begin
        op_vld_d = op_vld_q;
        op_id_d  = op_id_q;
        op_x_d   = op_x_q;
        op_y_d   = op_y_q;
        ptr_d    = ptr_q;
        if (adv_a) begin
            op_vld_d = grant_vld;
            if (grant_vld) begin
                op_id_d = grant_idx;
                op_x_d  = sel_x;
                op_y_d  = sel_y;
                ptr_d   = ptr_next;
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        if (adv_b) begin
            rsp_valid_d    = 1'b1;
            rsp_id_d       = op_id_q;
            rsp_res_d.cout = csla_cout;
            rsp_res_d.sum  = csla_sum;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vld_q    <= 1'b0;
            op_id_q     <= '0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            ptr_q       <= '0;
        end else begin
            op_vld_q    <= op_vld_d;
            op_id_q     <= op_id_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            ptr_q       <= ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_res_q.sum;
    assign rsp_cout  = rsp_res_q.cout;

endmodule

// File: doc/csla_arbiter.md
# csla_arbiter

Shares the single 32-bit carry-select adder `csla` among `NUM_REQ` requesters. The block performs round-robin arbitration, registers the granted operands, and drives them into one `csla` instance. It then registers the sum, carry-out and requester ID into a valid/ready response port. It sits between the operand-producing clients and the result consumer, and gives a throughput of one addition per clock.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default 2: width of the requester ID; must equal ceil(log2(NUM_REQ)).
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `req_valid`, input, NUM_REQ: per-requester operand valid.
- `req_ready`, output, NUM_REQ: per-requester accept; one-hot or zero.
- `req_x`, input, NUM_REQ*32: operand x; requester i occupies bits [32i+31:32i].
- `req_y`, input, NUM_REQ*32: operand y; same packing as `req_x`.
- `rsp_valid`, output, 1: result valid.
- `rsp_ready`, input, 1: consumer accept.
- `rsp_id`, output, ID_W: index of the requester that owns the result.
- `rsp_sum`, output, 32: x+y modulo 2^32.
- `rsp_cout`, output, 1: carry-out of x+y.

## Operation
- Pipeline stage A (operand register): `op_vld`, `op_id`, `op_x`, `op_y`.
- Pipeline stage B (result register): `rsp_valid`, `rsp_id`, `rsp_sum`, `rsp_cout`.
- The `csla` instance is purely combinational from `op_x`/`op_y` into stage B.
- Stage advance conditions:
  - `adv_b` = `op_vld` && (!`rsp_valid` || `rsp_ready`).
  - `adv_a` = !`op_vld` || `adv_b`.
- Arbitration, evaluated only when `adv_a` is high:
  - Search starts at requester index `ptr`; the first i with `req_valid[i]` set wins.
  - `req_ready[i]` is asserted combinationally for the winner only.
  - A transfer occurs when `req_valid[i]` && `req_ready[i]`.
- On a transfer:
  - Stage A loads that requester's x, y and ID; `op_vld` = 1.
  - `ptr` = (i+1) mod NUM_REQ.
- When `adv_b` is high with no new transfer, `op_vld` clears.
- When `adv_b` is high, stage B loads the csla outputs and `op_id`, and `rsp_valid` = 1.
- When `rsp_valid` && `rsp_ready` with no `adv_b`, `rsp_valid` clears.
- With no valid requests, `ptr` holds and `req_ready` = 0.
- `req_ready` must not depend on `req_valid` of lower-priority requesters beyond the winner search, and must not depend on the operand data.
- Requesters must hold `req_valid` and operands stable until accepted.
- No arithmetic overflow handling beyond `rsp_cout`; the 33-bit result is {`rsp_cout`, `rsp_sum`}.

## Timing
- Reset values (asynchronous, applied immediately when `rst_n`=0):
  - `op_vld`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0.
  - `ptr`=0, so requester 0 has highest priority after reset.
  - `req_ready`=0 while `rst_n` is low.
- Latency: a transfer at rising edge N gives `rsp_valid`=1 after edge N+1, provided stage B is free.
- Throughput: with `rsp_ready` held high, one result per cycle; back-to-back grants rotate round-robin.
- Backpressure:
  - `rsp_valid` high and `rsp_ready` low: B holds. `op_vld` is high, so A also holds and `req_ready`=0. Both stages full; no data loss.
  - Release: on the edge where `rsp_ready` is high, B takes A, and A may take a new grant in the same cycle.
- Simultaneous requests from all requesters give grants in order ptr, ptr+1, … with wrap-around from NUM_REQ-1 to 0.
- Reset mid-operation: in-flight operands and results are discarded; no response is emitted for them.

## Structure
- Shared package `csla_pkg`:
  - `CSLA_W` = 32.
  - typedef `csla_word_t` (32-bit).
  - typedef `csla_result_t` = {cout, sum}.
- Sub-module `csla_rr_arb`: round-robin winner search and pointer update (inputs `req_valid`, `ptr`, enable; outputs one-hot grant and index).
- The existing `csla(x,y,s,cout)` is instantiated once, unmodified.

## Test plan
- Single request, after reset: req 0 sends x=32'h56745675, y=32'h54546576, `rsp_ready`=1 → two cycles later `rsp_valid`=1, id=0, sum=32'hAAC8BBEB, cout=0.
- Carry-out: req 2 sends x=32'hAB674594, y=32'hAC784387 → sum=32'h57DF891B, cout=1, id=2.
- Fairness: all 4 requesters valid continuously, `rsp_ready`=1 → grants in order 0,1,2,3,0,1; results arrive one per cycle with matching ids.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with requests pending:
  - `rsp_valid` stays 1 and data stays stable.
  - `req_ready`=0 after A fills.
  - On release, results drain in grant order with no loss or duplication.
- Wrap-around: only req 3 and req 0 valid, `ptr` starting at 3 → grant 3, then 0, then 3.
- Reset mid-flight: assert `rst_n`=0 while both stages are full → outputs zero immediately; after release, the first grant goes to the lowest-index valid requester.
